squarer_arb_ctrl: RTL and testbench

SQUARER_ARB_CTRL -- requirements
Module: squarer_arb_ctrl

---
 rtl/squarer_arb_ctrl.sv | 142 ++++++++++++++
 tb/tb_squarer_arb_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/squarer_arb_ctrl.sv
// Round-robin arbiter feeding one shared 8-bit squarer, with a result holding register and a ready/valid handshake.
// Optional result self-check is enabled by defining SQ_SELF_CHECK_EN.

module squarer_8bit (
    input  logic [7:0]  i_a,
    output logic [15:0] o_y,
    output logic        o_garbageA,
    output logic        o_garbageB
);
    assign o_y        = 16'(i_a) * 16'(i_a);
    assign o_garbageA = ^i_a;
    assign o_garbageB = &i_a;
endmodule

module squarer_arb_ctrl #(
    parameter int NREQ        = 4,
    parameter int CALC_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [8*NREQ-1:0] op_in,
    output logic [NREQ-1:0]   gnt,
    output logic [15:0]       res_y,
    output logic [1:0]        res_id,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              busy,
    output logic              err
);
    typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [7:0]        r_opReg;
    logic [1:0]        r_lastId;
    logic [1:0]        r_winId;
    logic [NREQ-1:0]   r_gnt;
    logic [15:0]       r_resY;
    logic [1:0]        r_resId;
    logic              r_resValid;

    logic              w_anyReq;
    logic [1:0]        w_winner;
    logic [1:0]        w_idx;
    logic [7:0]        w_winOp;
    logic [15:0]       w_sqY;

    squarer_8bit u_squarer (
        .i_a        (r_opReg),
        .o_y        (w_sqY),
        .o_garbageA (),
        .o_garbageB ()
    );

    // Walk from the farthest offset back to the nearest so the requester right after last_id wins.
    always_comb begin
        w_anyReq = 1'b0;
        w_winner = r_lastId;
        w_idx    = r_lastId;
        for (int k = NREQ; k >= 1; k--) begin
            w_idx = r_lastId + 2'(k);
            if (req[w_idx]) begin
                w_anyReq = 1'b1;
                w_winner = w_idx;
            end
        end
    end

    assign w_winOp = op_in[{w_winner, 3'b000} +: 8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_opReg    <= '0;
            r_lastId   <= 2'd3;
            r_winId    <= '0;
            r_gnt      <= '0;
            r_resY     <= '0;
            r_resId    <= '0;
            r_resValid <= 1'b0;
        end else begin
            r_gnt <= '0;
            case (r_state)
                IDLE: begin
                    if (w_anyReq) begin
                        r_gnt[w_winner] <= 1'b1;
                        r_opReg         <= w_winOp;
                        r_winId         <= w_winner;
                        r_cnt           <= 3'(CALC_CYCLES);
                        r_state         <= CALC;
                    end
                end
                CALC: begin
                    r_cnt <= r_cnt - 3'd1;
                    if (r_cnt == 3'd1) begin
                        r_resY     <= w_sqY;
                        r_resId    <= r_winId;
                        r_resValid <= 1'b1;
                        r_state    <= HOLD;
                    end
                end
                HOLD: begin
                    // No grant on the handshake cycle; arbitration resumes from IDLE next cycle.
                    if (res_ready) begin
                        r_resValid <= 1'b0;
                        r_lastId   <= r_resId;
                        r_state    <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef SQ_SELF_CHECK_EN
    logic [15:0] w_refY;
    logic        r_err;

    assign w_refY = {8'd0, r_opReg} * {8'd0, r_opReg};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (r_state == CALC && r_cnt == 3'd1 && w_sqY != w_refY) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    assign err = 1'b0;
`endif

    assign gnt       = r_gnt;
    assign res_y     = r_resY;
    assign res_id    = r_resId;
    assign res_valid = r_resValid;
    assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_squarer_arb_ctrl.sv
// Scoreboard bench for squarer_arb_ctrl: a transaction-level model predicts grants and results,
// a negedge monitor compares whatever the DUT presents against the queued expectations.

module tb_squarer_arb_ctrl;
    localparam int CC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] opIn = '0;
    logic        resReady = 1'b0;
    logic [3:0]  gnt;
    logic [15:0] resY;
    logic [1:0]  resId;
    logic        resValid;
    logic        busy;
    logic        err;

    squarer_arb_ctrl #(.NREQ(4), .CALC_CYCLES(CC)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .op_in     (opIn),
        .gnt       (gnt),
        .res_y     (resY),
        .res_id    (resId),
        .res_valid (resValid),
        .res_ready (resReady),
        .busy      (busy),
        .err       (err)
    );

    always #5 clk = ~clk;

    typedef struct {int gntCycle; logic [3:0] gnt;} gntItem_t;
    typedef struct {int gntCycle; logic [1:0] id; logic [15:0] y;} resItem_t;

    gntItem_t gntQ[$];
    resItem_t resQ[$];

    int       cyc = 0;
    int       vectors = 0;
    int       miscompares = 0;
    bit       mBusy = 1'b0;
    int       mSince = 0;
    logic [1:0] mLast = 2'd3;
    logic [1:0] mWin = 2'd0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1:0] rrWinner(input logic [3:0] r, input logic [1:0] last);
        for (int k = 1; k <= 4; k++) begin
            int idx;
            idx = (int'(last) + k) % 4;
            if (r[idx]) return 2'(idx);
        end
        return 2'd0;
    endfunction

    // Drive one cycle of inputs and advance the transaction model to the next edge.
    task automatic driveAndModel(input logic [3:0] reqv, input logic [31:0] ops, input logic ready);
        logic [1:0] w;
        logic [7:0] o;
        req      = reqv;
        opIn     = ops;
        resReady = ready;
        if (!mBusy) begin
            if (reqv != 4'd0) begin
                w = rrWinner(reqv, mLast);
                o = ops[8*w +: 8];
                gntQ.push_back('{cyc + 1, 4'(1) << w});
                resQ.push_back('{cyc + 1, w, 16'(o) * 16'(o)});
                mBusy  = 1'b1;
                mSince = 0;
                mWin   = w;
            end
        end else if (mSince >= CC && ready) begin
            mBusy = 1'b0;
            mLast = mWin;
        end else begin
            mSince++;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqv, input logic [31:0] ops, input logic ready);
        @(posedge clk);
        #1;
        driveAndModel(reqv, ops, ready);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 * CC + 8 && mBusy; i++) applyStimulus(4'd0, 32'd0, 1'b1);
        applyStimulus(4'd0, 32'd0, 1'b1);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_gnt"}, 32'(gnt), 32'd0);
        checkOutput({tag, "_res_valid"}, 32'(resValid), 32'd0);
        checkOutput({tag, "_res_y"}, 32'(resY), 32'd0);
        checkOutput({tag, "_res_id"}, 32'(resId), 32'd0);
        checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
        checkOutput({tag, "_err"}, 32'(err), 32'd0);
    endtask

    // Monitor: grants are checked on their predicted cycle, results from their due cycle until accepted.
    always @(negedge clk) begin
        logic [3:0] expGnt;
        if (!rst) begin
            expGnt = (gntQ.size() > 0 && gntQ[0].gntCycle == cyc) ? gntQ[0].gnt : 4'd0;
            if (gnt != 4'd0 || expGnt != 4'd0) begin
                checkOutput("gnt", 32'(gnt), 32'(expGnt));
                if (expGnt != 4'd0) begin
                    checkOutput("busy_on_gnt", 32'(busy), 32'd1);
                    void'(gntQ.pop_front());
                end
            end
            if (resQ.size() > 0 && cyc >= resQ[0].gntCycle + CC) begin
                checkOutput("res_valid", 32'(resValid), 32'd1);
                if (resValid) begin
                    checkOutput("res_y", 32'(resY), 32'(resQ[0].y));
                    checkOutput("res_id", 32'(resId), 32'(resQ[0].id));
                    checkOutput("err", 32'(err), 32'd0);
                end
                if (resReady) void'(resQ.pop_front());
            end else if (resValid) begin
                checkOutput("spurious_valid", 32'(resValid), 32'd0);
            end
        end
    end

    initial begin
        logic [7:0] corners [3];
        corners[0] = 8'h00;
        corners[1] = 8'hFF;
        corners[2] = 8'h80;

        #2;
        checkResetValues("init");

        // Request present on the first cycle after release: grant on the very next edge.
        @(posedge clk);
        #1;
        rst = 1'b0;
        driveAndModel(4'b0001, 32'h0000_000D, 1'b1);
        drain();

        for (int i = 0; i < 3; i++) begin
            applyStimulus(4'b0100, {8'h11, corners[i], 8'h22, 8'h33}, 1'b1);
            drain();
        end

        // Backpressure: held in HOLD for at least ten cycles while other requests wait.
        applyStimulus(4'b0010, 32'h0000_0300, 1'b0);
        for (int i = 0; i < CC + 10; i++) applyStimulus(4'hF, $urandom, 1'b0);
        drain();

        // Reset one cycle after a grant discards the in-flight operation.
        applyStimulus(4'b0100, 32'h00AB_0000, 1'b0);
        applyStimulus(4'b0000, 32'd0, 1'b0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        checkResetValues("midcalc");
        gntQ.delete();
        resQ.delete();
        mBusy = 1'b0;
        mLast = 2'd3;
        req   = 4'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        driveAndModel(4'd0, 32'd0, 1'b1);
        for (int i = 0; i < 15; i++) applyStimulus(4'd0, 32'd0, 1'b1);

        // Fairness from a fresh reset: order 0,1,2,3,0.
        for (int i = 0; i < 5 * (CC + 2) + 2; i++) applyStimulus(4'hF, $urandom, 1'b1);
        drain();

        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
            applyStimulus(r, $urandom, $urandom_range(0, 3) != 0);
        end
        drain();

        for (int v = 0; v < 256; v++) begin
            logic [7:0] b;
            b = 8'(v);
            applyStimulus(4'(1) << (v % 4), {b, b, b, b}, 1'b1);
            drain();
        end

        checkOutput("gnt_queue_empty", 32'(gntQ.size()), 32'd0);
        checkOutput("res_queue_empty", 32'(resQ.size()), 32'd0);
        checkOutput("err_final", 32'(err), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
